// File: rtl/fir_mac_datapath_if.sv
// fir_mac_datapath_if
//   Bundles the sample, controller-strobe, coefficient-write and result
//   signals of the FIR MAC datapath.
//   master : the side that produces samples, controller strobes and
//            coefficient writes (controller plus host, or a testbench).
//   slave  : the datapath itself.
//   Signals:
//     sample, x_in         new-sample strobe and value
//     clr, oe              controller strobes (idle window / output load)
//     coef_we/addr/data    coefficient register-file write port
//     co                   tap-counter carry back to the controller
//     y_out, y_valid       filtered output and its one-cycle update pulse
//     overrun              sticky dropped-sample flag
interface fir_mac_datapath_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
);
  localparam int AW = $clog2(TAPS);

  logic              sample;
  logic [DATA_W-1:0] x_in;
  logic              clr;
  logic              oe;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              co;
  logic [DATA_W-1:0] y_out;
  logic              y_valid;
  logic              overrun;

  modport master (
    output sample, x_in, clr, oe, coef_we, coef_addr, coef_data,
    input  co, y_out, y_valid, overrun
  );

  modport slave (
    input  sample, x_in, clr, oe, coef_we, coef_addr, coef_data,
    output co, y_out, y_valid, overrun
  );
endinterface

// File: rtl/fir_mac_datapath.sv
// fir_mac_datapath
//   Multiply-accumulate datapath of a TAPS-long FIR filter, sequenced by an
//   external controller through clr (idle window) and oe (output load).
//   Holds the sample delay line, coefficient register file, tap counter k
//   and accumulator. One output per accepted sample, TAPS+2 cycles apart.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    fir_mac_datapath_if.slave (see interface file for signals)
//   Configuration macro:
//     FIR_SAT_EN  defined   -> y_out saturates to the DATA_W signed range
//                 undefined -> y_out keeps the low DATA_W bits (wraps)
module fir_mac_datapath #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = 40
) (
  input  logic               clk,
  input  logic               reset,
  fir_mac_datapath_if.slave  bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;
  localparam int SH = COEF_W - 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
  // TAPS modulo 2^AW; adding it undoes a negative wrap of newest-k.
  localparam logic [AW-1:0] TAPS_MOD = AW'(TAPS);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  logic signed [DATA_W-1:0] mem_r  [TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic [AW-1:0]            wp_r;
  logic [AW-1:0]            k_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [DATA_W-1:0]        y_out_r;
  logic                     y_valid_r;
  logic                     overrun_r;

  logic [AW-1:0]            newest_s;
  logic [AW-1:0]            rd_idx_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic [DATA_W-1:0]        y_next_s;

  // Delay-line read address: the sample k steps older than the newest one.
  always_comb begin
    newest_s = '0;
    rd_idx_s = '0;
    if (wp_r == '0) begin
      newest_s = LAST_IDX;
    end else begin
      newest_s = wp_r - ONE_IDX;
    end
    if (newest_s >= k_r) begin
      rd_idx_s = newest_s - k_r;
    end else begin
      rd_idx_s = newest_s - k_r + TAPS_MOD;
    end
  end

  // Signed tap product, sign-extended to the accumulator width.
  always_comb begin
    prod_s     = mem_r[rd_idx_s] * coef_r[k_r];
    prod_ext_s = {{(ACC_W - PW){prod_s[PW-1]}}, prod_s};
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  logic signed [ACC_W-1:0] shifted_s;

  // Rescale Q-format sum and clamp to the signed output range.
  always_comb begin
    shifted_s = acc_r >>> SH;
    if (shifted_s > SAT_MAX) begin
      y_next_s = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      y_next_s = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      y_next_s = shifted_s[DATA_W-1:0];
    end
  end
`else
  // Rescale Q-format sum; the low DATA_W bits of acc>>>SH are this slice.
  always_comb begin
    y_next_s = acc_r[SH + DATA_W - 1:SH];
  end
`endif

  // Delay line, coefficients, tap counter, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_r[i]  <= '0;
        coef_r[i] <= '0;
      end
      wp_r      <= '0;
      k_r       <= '0;
      acc_r     <= '0;
      y_out_r   <= '0;
      y_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else if (bus.clr) begin
      // Idle window: clr wins over oe, so y_out is never loaded here.
      acc_r     <= '0;
      k_r       <= '0;
      y_valid_r <= 1'b0;
      if (bus.sample) begin
        mem_r[wp_r] <= bus.x_in;
        wp_r        <= (wp_r == LAST_IDX) ? '0 : wp_r + ONE_IDX;
      end
      // Addresses beyond TAPS-1 exist only for non-power-of-two lengths.
      if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
        coef_r[bus.coef_addr] <= bus.coef_data;
      end
    end else begin
      // Busy window: samples are dropped, coefficient writes ignored.
      if (bus.sample) begin
        overrun_r <= 1'b1;
      end
      if (bus.oe) begin
        y_out_r   <= y_next_s;
        y_valid_r <= 1'b1;
      end else begin
        acc_r     <= acc_r + prod_ext_s;
        y_valid_r <= 1'b0;
        if (k_r != LAST_IDX) begin
          k_r <= k_r + ONE_IDX;
        end
      end
    end
  end

  // Carry is combinational so the controller sees it on the last tap itself.
  assign bus.co      = (k_r == LAST_IDX) && !bus.clr;
  assign bus.y_out   = y_out_r;
  assign bus.y_valid = y_valid_r;
  assign bus.overrun = overrun_r;
endmodule

// File: doc/fir_mac_datapath.md
# fir_mac_datapath

FIR multiply-accumulate datapath paired with the `firControl` sequencer. It holds the sample delay line, the coefficient register file, the tap counter and the accumulator. It consumes the controller's `clr` and `oe` strobes and returns `co` when the last tap is being accumulated. One filter output is produced per accepted input sample, with a throughput of one sample every TAPS+2 cycles.

## Interface
- `DATA_W`, 16: signed sample and output width (Q1.15 at default).
- `COEF_W`, 16: signed coefficient width (Q1.(COEF_W-1)).
- `TAPS`, 8: filter length. Legal range 2..64; any value in that range is allowed.
- `ACC_W`, 40: accumulator width. Must be at least DATA_W+COEF_W+clog2(TAPS).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sample`  in  1: new-sample strobe. The same wire also drives `firControl.sample`.
- `x_in`  in  DATA_W: sample value, qualified by `sample`.
- `clr`  in  1: from controller. Clears the accumulator and tap counter; marks the idle window.
- `oe`  in  1: from controller. Loads the output register.
- `coef_we`  in  1: coefficient write strobe.
- `coef_addr`  in  clog2(TAPS): coefficient index.
- `coef_data`  in  COEF_W: coefficient value.
- `co`  out  1: tap-counter carry to the controller.
- `y_out`  out  DATA_W: filtered output, held between updates.
- `y_valid`  out  1: one-cycle pulse when `y_out` updates.
- `overrun`  out  1: sticky flag. Set when a sample is dropped.

## Operation
- Reset (sync, active-high):
  - Delay line, write pointer `wp`, tap counter `k`, accumulator, coefficients, `y_out`, `y_valid` and `overrun` all go to 0.
  - `co` = 0.
- Sample accept:
  - `sample`=1 with `clr`=1 writes `x_in` to `mem[wp]`.
  - `wp` then advances, wrapping from TAPS-1 to 0.
  - `newest` = `wp`-1 mod TAPS. It stays constant while the MAC runs.
- Sample drop:
  - `sample`=1 with `clr`=0 (MAC or DATAOUT window) discards the sample.
  - `overrun` is set and stays set until reset.
- Coefficient write:
  - Accepted only while `clr`=1: `coef[coef_addr]` <= `coef_data` at the clock edge.
  - Writes with `clr`=0 are ignored, so coefficients never change mid-computation.
- MAC (`clr`=0, `oe`=0), once per cycle:
  - acc <= acc + sext(mem[(newest-k) mod TAPS] * coef[k]).
  - The product is signed, DATA_W+COEF_W bits, sign-extended to ACC_W.
  - `k` increments and saturates at TAPS-1.
- `co` is combinational: (`k`==TAPS-1) && !`clr`.
- DATAOUT (`oe`=1):
  - No accumulation; `k` holds.
  - `y_out` <= acc >>> (COEF_W-1), arithmetic shift, reduced to DATA_W. The reduction depends on the macro (see Configuration).
  - `y_valid` <= 1 for exactly one cycle.
- Idle (`clr`=1): acc <= 0, `k` <= 0, `y_valid` <= 0. `y_out` holds.
- Simultaneous `clr` and `oe`: `clr` wins. acc and `k` clear; `y_out` is not loaded.
- Reset mid-MAC: the partial sum is discarded and no `y_valid` is issued. The delay line and coefficients are cleared.

## Timing
- Cycle t: `sample` accepted while the controller is in RESET.
- Cycles t+1 .. t+TAPS: MAC runs, with `k` = 0..TAPS-1. `co`=1 at t+TAPS.
- Cycle t+TAPS+1: `oe`=1.
- Cycle t+TAPS+2:
  - `y_valid`=1 and the new `y_out` is visible.
  - The controller is back in RESET; a new sample is acceptable in this same cycle.
- Latency from sample to `y_valid`: TAPS+2 cycles. Minimum sample spacing: TAPS+2 cycles.
- Delay-line and coefficient reads are combinational (register file). There is no read latency.

## Configuration
- `FIR_SAT_EN` defined:
  - A shifted result above 2^(DATA_W-1)-1 clamps to 0x7FFF (default width).
  - A result below -2^(DATA_W-1) clamps to 0x8000.
- `FIR_SAT_EN` undefined: `y_out` takes the low DATA_W bits of the shifted result (two's-complement wrap).

## Test plan
All scenarios use TAPS=4, DATA_W=COEF_W=16 and the controller connected.
- Reset check: assert `reset` for 2 cycles -> `y_out`=0, `y_valid`=0, `co`=0, `overrun`=0.
- Impulse response: coef = {0x4000, 0x2000, 0x1000, 0x0800}; samples 0x1000, 0, 0, 0 spaced 6 cycles apart -> `y_out` = 0x0800, 0x0400, 0x0200, 0x0100. Each `y_valid` comes exactly 6 cycles after its sample.
- Saturation: all coef = 0x7FFF; four samples of 0x7FFF -> the fourth output is 0x7FFF with `FIR_SAT_EN`, and 0xFFF8 without it.
- Overrun: pulse `sample` 2 cycles after an accepted sample -> `overrun`=1 and the dropped value never appears in the delay line. The next output equals the impulse-test value.
- Coefficient-write guard: write coef[0]=0x7FFF during MAC -> ignored, and the output uses the old coefficient. The same write during idle takes effect on the next sample.
- Reset mid-MAC: assert `reset` at t+2 -> no `y_valid` pulse; the next sample 0x1000 yields 0x0800 (coefficients reloaded after reset).
